// File: rtl/axi_stream_if.sv
// AXI-stream channel bundle (data/valid/ready/last) shared by the CSR source and its consumers.
// The master drives data/valid/last and the slave drives ready.
interface axi_stream_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/csr_stream_source.sv
// CSR matrix source: reads values, column indices and row pointers from three synchronous-read
// memories and streams them out on three independent AXI-stream masters.
module csr_stream_source #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 32,
    parameter int MAX_NNZ    = 1024,
    parameter int MAX_ROWS   = 256,
    parameter int BUF_DEPTH  = 4,
    localparam int NNZ_W     = $clog2(MAX_NNZ + 1),
    localparam int ROW_W     = $clog2(MAX_ROWS + 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NNZ_W-1:0]      nnz,
    input  logic [ROW_W-1:0]      n_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  val_mem_en,
    output logic [NNZ_W-1:0]      val_mem_addr,
    input  logic [DATA_WIDTH-1:0] val_mem_rdata,
    output logic                  col_mem_en,
    output logic [NNZ_W-1:0]      col_mem_addr,
    input  logic [IDX_WIDTH-1:0]  col_mem_rdata,
    output logic                  row_mem_en,
    output logic [ROW_W-1:0]      row_mem_addr,
    input  logic [IDX_WIDTH-1:0]  row_mem_rdata,
    axi_stream_if.master          val,
    axi_stream_if.master          c_idx,
    axi_stream_if.master          r_beg
);
    // Channel 0 = val, 1 = c_idx, 2 = r_beg; all share one widened datapath.
    localparam int NCH = 3;
    localparam int AW  = (NNZ_W > ROW_W) ? NNZ_W : ROW_W;
    localparam int DW  = (DATA_WIDTH > IDX_WIDTH) ? DATA_WIDTH : IDX_WIDTH;
    localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int FW  = $clog2(BUF_DEPTH + 1) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  total  [NCH];
    logic [AW-1:0]  issued [NCH];
    logic [AW-1:0]  sent   [NCH];
    logic [PW-1:0]  rd_ptr [NCH];
    logic [PW-1:0]  wr_ptr [NCH];
    logic [FW-1:0]  count  [NCH];
    logic [DW-1:0]  rdata  [NCH];
    logic [DW-1:0]  head   [NCH];
    logic [DW-1:0]  fifo_mem [NCH][BUF_DEPTH];
    logic [NCH-1:0] inflight, issue, push, pop, valid, is_last, drained, ready;
    logic [NNZ_W-1:0] nnz_sat;
    logic [ROW_W-1:0] rows_sat;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign nnz_sat  = (nnz > NNZ_W'(MAX_NNZ)) ? NNZ_W'(MAX_NNZ) : nnz;
    assign rows_sat = (n_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : n_rows;

    assign rdata[0] = DW'(val_mem_rdata);
    assign rdata[1] = DW'(col_mem_rdata);
    assign rdata[2] = DW'(row_mem_rdata);
    assign ready    = {r_beg.ready, c_idx.ready, val.ready};

    // Credits cover buffered beats plus the read still in flight, so a push always has room.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            valid[c]   = (count[c] != '0);
            pop[c]     = valid[c] && ready[c];
            push[c]    = inflight[c];
            issue[c]   = (state == ST_RUN) && (issued[c] < total[c]) &&
                         ((count[c] + FW'(inflight[c])) < FW'(BUF_DEPTH));
            drained[c] = (sent[c] == total[c]);
            is_last[c] = valid[c] && (sent[c] == total[c] - AW'(1));
            head[c]    = fifo_mem[c][rd_ptr[c]];
        end
    end

    // NOTE: every variable of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (&drained) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            inflight <= '0;
            for (int c = 0; c < NCH; c++) begin
                total[c]  <= '0;
                issued[c] <= '0;
                sent[c]   <= '0;
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                total[0] <= AW'(nnz_sat);
                total[1] <= AW'(nnz_sat);
                total[2] <= AW'(rows_sat) + AW'(1);
                inflight <= '0;
                for (int c = 0; c < NCH; c++) begin
                    issued[c] <= '0;
                    sent[c]   <= '0;
                    rd_ptr[c] <= '0;
                    wr_ptr[c] <= '0;
                    count[c]  <= '0;
                end
            end else begin
                inflight <= issue;
                for (int c = 0; c < NCH; c++) begin
                    if (issue[c]) issued[c] <= issued[c] + AW'(1);
                    if (pop[c]) begin
                        sent[c]   <= sent[c] + AW'(1);
                        rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                    end
                    if (push[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                    if (push[c] && !pop[c])      count[c] <= count[c] + FW'(1);
                    else if (!push[c] && pop[c]) count[c] <= count[c] - FW'(1);
                end
            end
        end
    end

    // NOTE: FIFO storage is not reset; the cleared pointers and counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) fifo_mem[c][wr_ptr[c]] <= rdata[c];
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    assign val_mem_en   = issue[0];
    assign val_mem_addr = issued[0][NNZ_W-1:0];
    assign col_mem_en   = issue[1];
    assign col_mem_addr = issued[1][NNZ_W-1:0];
    assign row_mem_en   = issue[2];
    assign row_mem_addr = issued[2][ROW_W-1:0];

    assign val.valid   = valid[0];
    assign val.data    = head[0][DATA_WIDTH-1:0];
    assign val.last    = is_last[0];
    assign c_idx.valid = valid[1];
    assign c_idx.data  = head[1][IDX_WIDTH-1:0];
    assign c_idx.last  = is_last[1];
    assign r_beg.valid = valid[2];
    assign r_beg.data  = head[2][IDX_WIDTH-1:0];
    assign r_beg.last  = is_last[2];
endmodule

// File: tb/tb_csr_stream_source.sv
// Directed bench for csr_stream_source: memory models with closed-form contents, a beat
// monitor, and immediate-assertion checks against hand-derived beat counts, data and timing.
module tb_csr_stream_source;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] nnz = '0;
    logic [8:0]  n_rows = '0;
    logic        busy, done;
    logic        val_mem_en, col_mem_en, row_mem_en;
    logic [10:0] val_mem_addr, col_mem_addr;
    logic [8:0]  row_mem_addr;
    logic [31:0] val_mem_rdata, col_mem_rdata, row_mem_rdata;
    logic        rdy_v = 1'b1, rdy_c = 1'b1, rdy_r = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_gaps = 0;
    bit got = 0;

    axi_stream_if #(.WIDTH(32)) val_s ();
    axi_stream_if #(.WIDTH(32)) cidx_s ();
    axi_stream_if #(.WIDTH(32)) rbeg_s ();

    assign val_s.ready  = rdy_v;
    assign cidx_s.ready = rdy_c;
    assign rbeg_s.ready = rdy_r;

    csr_stream_source dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nnz(nnz), .n_rows(n_rows),
        .busy(busy), .done(done),
        .val_mem_en(val_mem_en), .val_mem_addr(val_mem_addr), .val_mem_rdata(val_mem_rdata),
        .col_mem_en(col_mem_en), .col_mem_addr(col_mem_addr), .col_mem_rdata(col_mem_rdata),
        .row_mem_en(row_mem_en), .row_mem_addr(row_mem_addr), .row_mem_rdata(row_mem_rdata),
        .val(val_s), .c_idx(cidx_s), .r_beg(rbeg_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] exp_data(input int ch, input int i);
        case (ch)
            0:       return 32'hA000_0000 + 32'(i);
            1:       return 32'h0000_C000 + 32'(3 * i);
            default: return 32'h0000_0007 + 32'(16 * i);
        endcase
    endfunction

    logic [31:0] val_mem [1024];
    logic [31:0] col_mem [1024];
    logic [31:0] row_mem [512];

    always @(posedge clk) begin
        if (val_mem_en) val_mem_rdata <= val_mem[val_mem_addr[9:0]];
        if (col_mem_en) col_mem_rdata <= col_mem[col_mem_addr[9:0]];
        if (row_mem_en) row_mem_rdata <= row_mem[row_mem_addr];
    end

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;
    beat_t beats[$];

    logic [2:0]  m_valid, m_ready, m_last;
    logic [31:0] m_data [3];
    assign m_valid = {rbeg_s.valid, cidx_s.valid, val_s.valid};
    assign m_ready = {rbeg_s.ready, cidx_s.ready, val_s.ready};
    assign m_last  = {rbeg_s.last, cidx_s.last, val_s.last};
    assign m_data[0] = val_s.data;
    assign m_data[1] = cidx_s.data;
    assign m_data[2] = rbeg_s.data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Beat capture, stall-hold checks and done counting.
    logic [2:0]  stalled = '0;
    logic [31:0] held_data [3];
    logic [2:0]  held_last = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (stalled[c]) begin
                    check($sformatf("hold valid ch%0d", c), 64'(m_valid[c]), 64'd1);
                    check($sformatf("hold data ch%0d", c), 64'(m_data[c]), 64'(held_data[c]));
                    check($sformatf("hold last ch%0d", c), 64'(m_last[c]), 64'(held_last[c]));
                end
                if (m_valid[c] && m_ready[c]) beats.push_back('{c, m_data[c], m_last[c], cyc});
                stalled[c]   = m_valid[c] && !m_ready[c];
                held_data[c] = m_data[c];
                held_last[c] = m_last[c];
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic int beat_count(input int ch);
        int n = 0;
        foreach (beats[j]) if (beats[j].ch == ch) n++;
        return n;
    endfunction

    function automatic int beat_cyc(input int ch, input int k);
        int n = 0;
        foreach (beats[j]) begin
            if (beats[j].ch == ch) begin
                if (n == k) return beats[j].cyc;
                n++;
            end
        end
        return -1;
    endfunction

    task automatic check_stream(input string tag, input int ch, input int n);
        int k = 0;
        foreach (beats[j]) begin
            if (beats[j].ch == ch) begin
                if (k < n) begin
                    check($sformatf("%s data[%0d]", tag, k), 64'(beats[j].data), 64'(exp_data(ch, k)));
                    check($sformatf("%s last[%0d]", tag, k), 64'(beats[j].last), 64'(k == n - 1));
                end
                k++;
            end
        end
        check({tag, " count"}, 64'(k), 64'(n));
    endtask

    task automatic clear_log();
        beats.delete();
        done_cnt  = 0;
        busy_gaps = 0;
    endtask

    task automatic run_start(input logic [10:0] nz, input logic [8:0] nr);
        @(posedge clk); #1;
        start = 1'b1; nnz = nz; n_rows = nr;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start_cyc = cyc;
    endtask

    // mode 0: all ready; 1: val toggles, c_idx stalled 10 cycles; 2: all ready plus a stray start.
    task automatic run_until_done(input int mode, input int budget, output bit seen);
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge clk); #1;
            rdy_v = (mode == 1) ? (k % 2 == 0) : 1'b1;
            rdy_c = (mode == 1) ? (k >= 10) : 1'b1;
            rdy_r = 1'b1;
            if (mode == 2) begin
                start  = (k == 4);
                nnz    = (k == 4) ? 11'd2 : nnz;
                n_rows = (k == 4) ? 9'd1 : n_rows;
            end
            @(negedge clk);
            if (done) seen = 1;
            else if (!busy) busy_gaps++;
        end
        start = 1'b0;
        rdy_v = 1'b1; rdy_c = 1'b1; rdy_r = 1'b1;
    endtask

    task automatic settle_after_done(input string tag);
        repeat (3) @(negedge clk);
        check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " busy after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            val_mem[i] = exp_data(0, i);
            col_mem[i] = exp_data(1, i);
        end
        for (int i = 0; i < 512; i++) row_mem[i] = exp_data(2, i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst val_en", 64'(val_mem_en), 64'd0);
        check("rst col_en", 64'(col_mem_en), 64'd0);
        check("rst row_en", 64'(row_mem_en), 64'd0);
        check("rst val_addr", 64'(val_mem_addr), 64'd0);
        check("rst col_addr", 64'(col_mem_addr), 64'd0);
        check("rst row_addr", 64'(row_mem_addr), 64'd0);
        check("rst valids", 64'(m_valid), 64'd0);
        check("rst lasts", 64'(m_last), 64'd0);
        rst_n = 1'b1;

        // 1: nnz=5, n_rows=3, all ready
        clear_log();
        run_start(11'd5, 9'd3);
        run_until_done(0, 200, got);
        check("t1 done seen", 64'(got), 64'd1);
        check("t1 busy gaps", 64'(busy_gaps), 64'd0);
        settle_after_done("t1");
        check_stream("t1 val", 0, 5);
        check_stream("t1 cidx", 1, 5);
        check_stream("t1 rbeg", 2, 4);
        check("t1 first val latency", 64'(beat_cyc(0, 0) - start_cyc), 64'd2);
        check("t1 last val latency", 64'(beat_cyc(0, 4) - start_cyc), 64'd6);

        // 2: val ready toggling, c_idx stalled 10 cycles
        clear_log();
        run_start(11'd5, 9'd3);
        run_until_done(1, 200, got);
        check("t2 done seen", 64'(got), 64'd1);
        settle_after_done("t2");
        check_stream("t2 val", 0, 5);
        check_stream("t2 cidx", 1, 5);
        check_stream("t2 rbeg", 2, 4);
        check("t2 rbeg unaffected", 64'(beat_cyc(2, 3) - start_cyc), 64'd5);
        check("t2 cidx first after stall", 64'(beat_cyc(1, 0) - start_cyc >= 11), 64'd1);
        check("t2 done after cidx", 64'(done_cyc > beat_cyc(1, 4)), 64'd1);

        // 3: nnz=0, n_rows=0
        clear_log();
        run_start(11'd0, 9'd0);
        run_until_done(0, 100, got);
        check("t3 done seen", 64'(got), 64'd1);
        settle_after_done("t3");
        check("t3 val beats", 64'(beat_count(0)), 64'd0);
        check("t3 cidx beats", 64'(beat_count(1)), 64'd0);
        check_stream("t3 rbeg", 2, 1);

        // 4: nnz=64, back-to-back throughput
        clear_log();
        run_start(11'd64, 9'd3);
        run_until_done(0, 300, got);
        check("t4 done seen", 64'(got), 64'd1);
        settle_after_done("t4");
        check_stream("t4 val", 0, 64);
        check_stream("t4 cidx", 1, 64);
        check("t4 val start", 64'(beat_cyc(0, 0) - start_cyc), 64'd2);
        check("t4 val span", 64'(beat_cyc(0, 63) - beat_cyc(0, 0)), 64'd63);
        check("t4 cidx span", 64'(beat_cyc(1, 63) - beat_cyc(1, 0)), 64'd63);

        // 5: reset mid-stream after 3 val beats, then replay
        clear_log();
        run_start(11'd5, 9'd3);
        for (int k = 0; k < 50 && beat_count(0) < 3; k++) @(negedge clk);
        check("t5 reached 3 beats", 64'(beat_count(0) >= 3), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5 valids after rst", 64'(m_valid), 64'd0);
        check("t5 busy after rst", 64'(busy), 64'd0);
        check("t5 val_en after rst", 64'(val_mem_en), 64'd0);
        repeat (4) @(negedge clk);
        check("t5 no done from reset", 64'(done_cnt), 64'd0);
        clear_log();
        run_start(11'd5, 9'd3);
        run_until_done(0, 200, got);
        check("t5 done seen", 64'(got), 64'd1);
        settle_after_done("t5");
        check_stream("t5 val", 0, 5);
        check_stream("t5 rbeg", 2, 4);

        // 6: start re-pulsed during RUN
        clear_log();
        run_start(11'd5, 9'd3);
        run_until_done(2, 200, got);
        check("t6 done seen", 64'(got), 64'd1);
        settle_after_done("t6");
        check_stream("t6 val", 0, 5);
        check_stream("t6 cidx", 1, 5);
        check_stream("t6 rbeg", 2, 4);

        // Saturation: oversized nnz and n_rows clamp to 1024 and 256
        clear_log();
        run_start(11'h7FF, 9'h1FF);
        run_until_done(0, 1200, got);
        check("sat done seen", 64'(got), 64'd1);
        settle_after_done("sat");
        check_stream("sat val", 0, 1024);
        check_stream("sat rbeg", 2, 257);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
